// File: rtl/debug_step_ctrl.sv
// Run/halt/single-step sequencer for the debug button path; drives the core clock-enable.
// Optional DEBUG_STEP_CNT_EN adds a 16-bit completed-step counter output (step_count).
module debug_step_ctrl #(
    parameter int unsigned LONG_PRESS_CYC = 50_000_000,
    parameter int unsigned STEP_CYC       = 1,
    parameter int unsigned CNT_W          = 32,
    parameter bit          START_RUN      = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_flag,
    input  logic        key_value,
    input  logic        dbg_halt_req,
    output logic        cpu_en,
`ifdef DEBUG_STEP_CNT_EN
    output logic [15:0] step_count,
`endif
    output logic        step_done,
    output logic        led_run,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_HALT,
        S_PRESSED,
        S_STEP,
        S_RUN_ARM,
        S_RUN,
        S_HALT_WAIT
    } state_e;

    localparam state_e           RESET_STATE = START_RUN ? S_RUN : S_HALT;
    localparam logic [CNT_W-1:0] LONG_C      = CNT_W'(LONG_PRESS_CYC);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             cpu_en_q, cpu_en_d;
    logic             step_done_q, step_done_d;
    logic             led_run_q, led_run_d;
    logic             halted_q, halted_d;
    logic             press, release_evt;

    assign press       = key_flag & ~key_value;
    assign release_evt = key_flag & key_value;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        step_d  = step_q;
        if (dbg_halt_req) begin
            state_d = S_HALT;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_HALT: begin
                    if (press) begin
                        state_d = S_PRESSED;
                        hold_d  = ONE_C;
                    end
                end
                S_PRESSED: begin
                    hold_d = (hold_q < LONG_C) ? hold_q + ONE_C : hold_q;
                    // Reaching the long-press threshold takes priority over a coincident release.
                    if (hold_q >= LONG_C) begin
                        state_d = S_RUN_ARM;
                    end else if (release_evt) begin
                        state_d = S_STEP;
                        step_d  = '0;
                    end
                end
                S_STEP: begin
                    if (step_q >= STEP_LAST) state_d = S_HALT;
                    else                     step_d  = step_q + ONE_C;
                end
                S_RUN_ARM:   if (release_evt) state_d = S_RUN;
                S_RUN:       if (press)       state_d = S_HALT_WAIT;
                S_HALT_WAIT: if (release_evt) state_d = S_HALT;
                default:     state_d = S_HALT;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside the state change.
    always_comb begin
        cpu_en_d    = (state_d == S_STEP) || (state_d == S_RUN_ARM) || (state_d == S_RUN);
        led_run_d   = (state_d == S_RUN_ARM) || (state_d == S_RUN);
        halted_d    = (state_d == S_HALT);
        step_done_d = (state_q == S_STEP) && (state_d == S_HALT) && !dbg_halt_req;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= RESET_STATE;
            hold_q      <= '0;
            step_q      <= '0;
            cpu_en_q    <= START_RUN;
            step_done_q <= 1'b0;
            led_run_q   <= START_RUN;
            halted_q    <= ~START_RUN;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
            cpu_en_q    <= cpu_en_d;
            step_done_q <= step_done_d;
            led_run_q   <= led_run_d;
            halted_q    <= halted_d;
        end
    end

`ifdef DEBUG_STEP_CNT_EN
    logic [15:0] step_count_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       step_count_q <= '0;
        else if (step_done_d) step_count_q <= step_count_q + 16'd1;
    end

    assign step_count = step_count_q;
`endif

    assign cpu_en    = cpu_en_q;
    assign step_done = step_done_q;
    assign led_run   = led_run_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed bench for debug_step_ctrl (LONG_PRESS_CYC=100, STEP_CYC=3, START_RUN=0).
// Output vectors are compared as {cpu_en, step_done, led_run, halted}.
module tb_debug_step_ctrl;

    localparam int LONG = 100;
    localparam int STEP = 3;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_flag;
    logic key_value;
    logic dbg_halt_req;
    logic cpu_en;
    logic step_done;
    logic led_run;
    logic halted;
`ifdef DEBUG_STEP_CNT_EN
    logic [15:0] step_count;
`endif

    int vectors    = 0;
    int miscompares = 0;
    logic [3:0] obs;

    debug_step_ctrl #(
        .LONG_PRESS_CYC(LONG),
        .STEP_CYC      (STEP),
        .CNT_W         (32),
        .START_RUN     (1'b0)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .dbg_halt_req(dbg_halt_req),
        .cpu_en      (cpu_en),
`ifdef DEBUG_STEP_CNT_EN
        .step_count  (step_count),
`endif
        .step_done   (step_done),
        .led_run     (led_run),
        .halted      (halted)
    );

    always #5 sys_clk = ~sys_clk;

    assign obs = {cpu_en, step_done, led_run, halted};

    // Inputs change 1 time unit after the rising edge; outputs are observed at the same point.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pressEvt();
        key_flag  = 1'b1;
        key_value = 1'b0;
        cyc(1);
        key_flag  = 1'b0;
    endtask

    task automatic releaseEvt();
        key_flag  = 1'b1;
        key_value = 1'b1;
        cyc(1);
        key_flag  = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        cyc(2);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL reset_held: outs=%b expected 0001", obs);
        end
        sys_rst_n = 1'b1;
        cyc(1);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL reset_release: outs=%b expected 0001", obs);
        end
    endtask

    task automatic test_single_step();
        logic [3:0] exp_seq [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0101, 4'b0001};
        pressEvt();
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL step_pressed: outs=%b expected 0000", obs);
        end
        cyc(9);
        releaseEvt();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc(1);
            vectors++;
            if (obs !== exp_seq[i]) begin
                miscompares++;
                $display("[TB] FAIL step_seq%0d: outs=%b expected %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 2; n++) begin
            int en_cnt;
            int done_cnt;
            en_cnt   = 0;
            done_cnt = 0;
            pressEvt();
            releaseEvt();
            for (int i = 0; i < 6; i++) begin
                if (i > 0) cyc(1);
                if (cpu_en === 1'b1)    en_cnt++;
                if (step_done === 1'b1) done_cnt++;
            end
            vectors++;
            if (en_cnt !== STEP) begin
                miscompares++;
                $display("[TB] FAIL b2b_en_cycles%0d: got %0d expected %0d", n, en_cnt, STEP);
            end
            vectors++;
            if (done_cnt !== 1) begin
                miscompares++;
                $display("[TB] FAIL b2b_done_pulses%0d: got %0d expected 1", n, done_cnt);
            end
        end
    endtask

    task automatic test_long_press();
        pressEvt();
        cyc(LONG - 1);
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL long_before_threshold: outs=%b expected 0000", obs);
        end
        cyc(1);
        vectors++;
        if (obs !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL long_run_arm: outs=%b expected 1010", obs);
        end
        cyc(49);
        releaseEvt();
        vectors++;
        if (obs !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL long_release: outs=%b expected 1010", obs);
        end
        cyc(5);
        vectors++;
        if (obs !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL long_stays_run: outs=%b expected 1010", obs);
        end
    endtask

    task automatic test_run_halt();
        pressEvt();
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL halt_wait_entry: outs=%b expected 0000", obs);
        end
        cyc(4);
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL halt_wait_hold: outs=%b expected 0000", obs);
        end
        releaseEvt();
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL halt_after_release: outs=%b expected 0001", obs);
        end
        cyc(4);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL halt_no_step: outs=%b expected 0001", obs);
        end
    endtask

    task automatic test_dbg_halt();
        pressEvt();
        cyc(3);
        releaseEvt();
        cyc(1);
        vectors++;
        if (obs !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL dbg_step_cycle2: outs=%b expected 1000", obs);
        end
        dbg_halt_req = 1'b1;
        cyc(1);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL dbg_abort: outs=%b expected 0001", obs);
        end
        cyc(3);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL dbg_no_done: outs=%b expected 0001", obs);
        end
        pressEvt();
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL dbg_press_ignored: outs=%b expected 0001", obs);
        end
        releaseEvt();
        dbg_halt_req = 1'b0;
        cyc(4);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL dbg_release_ignored: outs=%b expected 0001", obs);
        end
    endtask

    task automatic test_async_reset();
        pressEvt();
        cyc(LONG);
        releaseEvt();
        vectors++;
        if (obs !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL areset_reach_run: outs=%b expected 1010", obs);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL areset_immediate: outs=%b expected 0001", obs);
        end
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(2);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL areset_after: outs=%b expected 0001", obs);
        end
    endtask

`ifdef DEBUG_STEP_CNT_EN
    task automatic test_step_count();
        vectors++;
        if (step_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL count_reset: step_count=%0d expected 0", step_count);
        end
        for (int i = 0; i < 5; i++) begin
            pressEvt();
            releaseEvt();
            cyc(5);
        end
        vectors++;
        if (step_count !== 16'd5) begin
            miscompares++;
            $display("[TB] FAIL count_five: step_count=%0d expected 5", step_count);
        end
    endtask
`endif

    initial begin
        sys_rst_n    = 1'b0;
        key_flag     = 1'b0;
        key_value    = 1'b1;
        dbg_halt_req = 1'b0;
        test_reset();
        test_single_step();
        test_back_to_back();
        test_long_press();
        test_run_halt();
        test_dbg_halt();
        test_async_reset();
`ifdef DEBUG_STEP_CNT_EN
        test_step_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
